hazard_scoreboard: RTL and testbench

//   Consumer side of the M-stage resolved destination (TrueA3/Check) path: tracks every in-flight

---
 rtl/cpu_defs.sv | 26 ++
 rtl/hz_port_check.sv | 62 ++++++
 rtl/hazard_scoreboard.sv | 97 +++++++++
 tb/tb_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared pipeline definitions for the hazard scoreboard: timing field widths,
// forward-select codes and the in-flight writer slot record.
package cpu_defs;

    localparam int TNEW_W = 2;
    localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [4:0]        a3;
        logic [TNEW_W-1:0] tnew;
        logic              cond;
    } slot_t;

    // Each stage advance brings a result one cycle closer; zero means it already exists.
    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/hz_port_check.sv
// One D-stage read port checked against the E, M and W writer slots:
// the youngest matching writer decides between stall, forward or regfile.
module hz_port_check
    import cpu_defs::*;
(
    input  logic [4:0]        r,
    input  logic [TNEW_W-1:0] tuse,
    input  slot_t             slot_e,
    input  slot_t             slot_m,
    input  slot_t             slot_w,
    input  logic [4:0]        m_true_a3,
    input  logic              m_check,
    output logic              stall,
    output logic [1:0]        fwd
);

    logic              active;
    logic              hit_e;
    logic              hit_m;
    logic              hit_w;
    logic              hit;
    logic [TNEW_W-1:0] sel_tnew;
    logic [1:0]        sel_code;

    // An unresolved cond writer in E may end up writing any register, so it matches every reader.
    // In M a cond writer only counts once its final destination is announced.
    always_comb begin
        active = (tuse != TUSE_NONE) && (r != 5'd0);
        hit_e  = slot_e.valid && slot_e.we && (slot_e.cond || (slot_e.a3 == r));
        hit_m  = slot_m.valid && slot_m.we &&
                 (slot_m.cond ? (m_check && (m_true_a3 == r)) : (slot_m.a3 == r));
        hit_w  = slot_w.valid && slot_w.we && (slot_w.a3 == r);

        hit      = 1'b0;
        sel_tnew = '0;
        sel_code = FWD_RF;
        if (hit_e) begin
            hit      = 1'b1;
            sel_tnew = slot_e.tnew;
            sel_code = FWD_E;
        end else if (hit_m) begin
            hit      = 1'b1;
            sel_tnew = slot_m.tnew;
            sel_code = FWD_M;
        end else if (hit_w) begin
            hit      = 1'b1;
            sel_tnew = slot_w.tnew;
            sel_code = FWD_W;
        end

        stall = 1'b0;
        fwd   = FWD_RF;
        if (active && hit) begin
            if (sel_tnew > tuse) begin
                stall = 1'b1;
            end else if (sel_tnew == '0) begin
                fwd = sel_code;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: keeps E/M/W writer slots, resolves cond-dest writers
// on their M->W advance and produces Stall plus the two D-stage forward selects.
module hazard_scoreboard
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        D_rs,
    input  logic [4:0]        D_rt,
    input  logic [TNEW_W-1:0] D_TuseRs,
    input  logic [TNEW_W-1:0] D_TuseRt,
    input  logic              D_WE,
    input  logic [4:0]        D_A3,
    input  logic [TNEW_W-1:0] D_Tnew,
    input  logic              D_Cond,
    input  logic              D_IsMD,
    input  logic              E_MDBusy,
    input  logic [4:0]        M_TrueA3,
    input  logic              M_Check,
    output logic              Stall,
    output logic [1:0]        D_FwdRs,
    output logic [1:0]        D_FwdRt
);

    slot_t slot_e;
    slot_t slot_m;
    slot_t slot_w;
    slot_t e_next;
    slot_t m_next;
    slot_t w_next;
    logic  stall_rs;
    logic  stall_rt;

    hz_port_check u_rs (
        .r         (D_rs),
        .tuse      (D_TuseRs),
        .slot_e    (slot_e),
        .slot_m    (slot_m),
        .slot_w    (slot_w),
        .m_true_a3 (M_TrueA3),
        .m_check   (M_Check),
        .stall     (stall_rs),
        .fwd       (D_FwdRs)
    );

    hz_port_check u_rt (
        .r         (D_rt),
        .tuse      (D_TuseRt),
        .slot_e    (slot_e),
        .slot_m    (slot_m),
        .slot_w    (slot_w),
        .m_true_a3 (M_TrueA3),
        .m_check   (M_Check),
        .stall     (stall_rt),
        .fwd       (D_FwdRt)
    );

    assign Stall = stall_rs || stall_rt || (D_IsMD && E_MDBusy);

    // A cond writer leaving M takes its announced destination; without one it writes nothing.
    always_comb begin
        e_next = '0;
        if (!Stall) begin
            e_next.valid = 1'b1;
            e_next.we    = D_WE;
            e_next.a3    = D_A3;
            e_next.tnew  = D_Tnew;
            e_next.cond  = D_Cond;
        end

        m_next      = slot_e;
        m_next.tnew = tnew_dec(slot_e.tnew);

        w_next      = slot_m;
        w_next.tnew = tnew_dec(slot_m.tnew);
        if (slot_m.cond) begin
            w_next.a3   = M_Check ? M_TrueA3 : 5'd0;
            w_next.cond = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_e <= '0;
            slot_m <= '0;
            slot_w <= '0;
        end else begin
            slot_e <= e_next;
            slot_m <= m_next;
            slot_w <= w_next;
        end
    end

    cond_resolved_in_m: assert property (@(posedge clk) disable iff (reset)
        !(slot_m.valid && slot_m.we && slot_m.cond && !M_Check));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_TuseRs;
    logic [1:0] D_TuseRt;
    logic       D_WE;
    logic [4:0] D_A3;
    logic [1:0] D_Tnew;
    logic       D_Cond;
    logic       D_IsMD;
    logic       E_MDBusy;
    logic [4:0] M_TrueA3;
    logic       M_Check;
    logic       Stall;
    logic [1:0] D_FwdRs;
    logic [1:0] D_FwdRt;

    int errors;
    int checks;

    hazard_scoreboard dut (
        .clk      (clk),
        .reset    (reset),
        .D_rs     (D_rs),
        .D_rt     (D_rt),
        .D_TuseRs (D_TuseRs),
        .D_TuseRt (D_TuseRt),
        .D_WE     (D_WE),
        .D_A3     (D_A3),
        .D_Tnew   (D_Tnew),
        .D_Cond   (D_Cond),
        .D_IsMD   (D_IsMD),
        .E_MDBusy (E_MDBusy),
        .M_TrueA3 (M_TrueA3),
        .M_Check  (M_Check),
        .Stall    (Stall),
        .D_FwdRs  (D_FwdRs),
        .D_FwdRt  (D_FwdRt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives the D-stage instruction fields, then lets the combinational decision settle.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                                 input logic we, input logic [4:0] a3, input logic [1:0] tnew,
                                 input logic cond, input logic is_md);
        D_rs     = rs;
        D_rt     = rt;
        D_TuseRs = tuse_rs;
        D_TuseRt = tuse_rt;
        D_WE     = we;
        D_A3     = a3;
        D_Tnew   = tnew;
        D_Cond   = cond;
        D_IsMD   = is_md;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        E_MDBusy = 1'b0;
        M_TrueA3 = 5'd0;
        M_Check  = 1'b0;
        applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0);
        checkOutput("reset_stall", Stall, 0);
        checkOutput("reset_fwdrs", D_FwdRs, 0);
        checkOutput("reset_fwdrt", D_FwdRt, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        $display("[TB] addu $1 then beq on $1");
        applyStimulus(0, 0, 3, 3, 1, 1, 1, 0, 0);
        checkOutput("t1_addu_nostall", Stall, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_beq_stall", Stall, 1);
        step();
        checkOutput("t1_beq_release", Stall, 0);
        checkOutput("t1_beq_fwd_m", D_FwdRs, 2);
        step();

        $display("[TB] lw $2 then addu reading $2");
        applyStimulus(0, 0, 3, 3, 1, 2, 2, 0, 0);
        checkOutput("t2_lw_nostall", Stall, 0);
        step();
        applyStimulus(2, 0, 1, 1, 1, 4, 1, 0, 0);
        checkOutput("t2_addu_stall", Stall, 1);
        step();
        checkOutput("t2_addu_release", Stall, 0);
        checkOutput("t2_addu_fwd_late", D_FwdRs, 0);
        step();
        applyStimulus(2, 0, 1, 3, 0, 0, 0, 0, 0);
        checkOutput("t2_or_nostall", Stall, 0);
        checkOutput("t2_or_fwd_w", D_FwdRs, 3);
        step();

        $display("[TB] cond-dest load resolving to $5");
        applyStimulus(0, 0, 3, 3, 1, 31, 2, 1, 0);
        checkOutput("t3_cond_issue", Stall, 0);
        step();
        applyStimulus(0, 5, 3, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_cond_in_e_stall", Stall, 1);
        applyStimulus(0, 6, 3, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_cond_in_e_any", Stall, 1);
        applyStimulus(0, 5, 3, 0, 0, 0, 0, 0, 0);
        step();
        M_TrueA3 = 5'd5;
        M_Check  = 1'b1;
        #1;
        checkOutput("t3_cond_in_m_stall", Stall, 1);
        applyStimulus(0, 6, 3, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_cond_in_m_other", Stall, 0);
        applyStimulus(0, 5, 3, 0, 0, 0, 0, 0, 0);
        step();
        M_Check  = 1'b0;
        M_TrueA3 = 5'd0;
        #1;
        checkOutput("t3_cond_in_w_nostall", Stall, 0);
        checkOutput("t3_cond_in_w_fwd", D_FwdRt, 3);
        applyStimulus(0, 6, 3, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_reader6_nostall", Stall, 0);
        checkOutput("t3_reader6_fwd", D_FwdRt, 0);
        step();

        $display("[TB] two writers of $3, youngest wins");
        applyStimulus(0, 0, 3, 3, 1, 3, 0, 0, 0);
        step();
        applyStimulus(0, 0, 3, 3, 1, 3, 0, 0, 0);
        step();
        applyStimulus(3, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_rs_nostall", Stall, 0);
        checkOutput("t4_rs_fwd_e", D_FwdRs, 1);
        checkOutput("t4_rt_zero_fwd", D_FwdRt, 0);
        applyStimulus(0, 3, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_rs_zero_fwd", D_FwdRs, 0);
        checkOutput("t4_rt_fwd_e", D_FwdRt, 1);
        applyStimulus(3, 0, 3, 3, 0, 0, 0, 0, 0);
        checkOutput("t4_unused_fwd", D_FwdRs, 0);
        checkOutput("t4_unused_stall", Stall, 0);
        step();

        $display("[TB] mflo $7 held by busy MDU");
        E_MDBusy = 1'b1;
        applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0);
        checkOutput("t5_busy_non_md", Stall, 0);
        applyStimulus(0, 0, 3, 3, 1, 7, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t5_md_stall_%0d", i), Stall, 1);
            step();
        end
        E_MDBusy = 1'b0;
        #1;
        checkOutput("t5_md_release", Stall, 0);
        step();
        applyStimulus(7, 0, 0, 3, 0, 0, 0, 0, 0);
        checkOutput("t5_mflo_in_e_stall", Stall, 1);
        step();
        checkOutput("t5_mflo_in_m_nostall", Stall, 0);
        checkOutput("t5_mflo_fwd_m", D_FwdRs, 2);
        step();

        $display("[TB] reset during lw load-use stall");
        applyStimulus(0, 0, 3, 3, 1, 2, 2, 0, 0);
        step();
        applyStimulus(2, 0, 0, 3, 0, 0, 0, 0, 0);
        checkOutput("t6_pre_reset_stall", Stall, 1);
        reset = 1'b1;
        #1;
        checkOutput("t6_in_reset_stall", Stall, 0);
        checkOutput("t6_in_reset_fwd", D_FwdRs, 0);
        #1;
        reset = 1'b0;
        step();
        checkOutput("t6_post_reset_stall", Stall, 0);
        checkOutput("t6_post_reset_fwdrs", D_FwdRs, 0);
        applyStimulus(0, 2, 3, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("t6_no_stale_stall", Stall, 0);
        checkOutput("t6_no_stale_fwdrt", D_FwdRt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
